speck_round_engine: RTL and testbench

Parametrised SPECK round engine for the cipher IP core. It runs a programmable number of SPECK rounds in either direction (encrypt or decrypt) on one 2·WORD_SIZE block. It takes one subkey per round through a valid/ready stream and holds the result until the consumer accepts it. It generalises the single-round decrypt FSM: any SPECK word size and rotation pair, both directions, multi-round iteration, full handshakes and async reset. It sits between the key-schedule unit and the block-level controller.

---
 rtl/speck_round_engine.sv | 136 +++++++++++++
 tb/tb_speck_round_engine.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/speck_round_engine.sv
// rtl/speck_round_engine.sv - iterative SPECK encrypt/decrypt round engine with stream handshakes
module speck_round_engine #(
  parameter int WORD_SIZE   = 16,
  parameter int ALPHA       = 7,
  parameter int BETA        = 2,
  parameter int ROUND_WIDTH = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mode,
  input  logic [2*WORD_SIZE-1:0]   in_data,
  input  logic [ROUND_WIDTH-1:0]   in_rounds,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WORD_SIZE-1:0]     key,
  input  logic                     key_valid,
  output logic                     key_ready,
  output logic [2*WORD_SIZE-1:0]   out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ROUND_WIDTH-1:0]   rounds_done,
  output logic [1:0]               state_response
);

  localparam int W = WORD_SIZE;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_KEY  = 2'd1,
    S_DONE = 2'd2,
    S_BAD  = 2'd3
  } state_t;

  state_t                 r_state;
  logic [W-1:0]           r_x;
  logic [W-1:0]           r_y;
  logic                   r_mode;
  logic [ROUND_WIDTH-1:0] r_remaining;
  logic [ROUND_WIDTH-1:0] r_rounds_done;
  logic [2*W-1:0]         r_out_data;
  logic                   r_out_valid;

  logic [W-1:0] w_enc_x;
  logic [W-1:0] w_enc_y;
  logic [W-1:0] w_dec_x;
  logic [W-1:0] w_dec_y;
  logic [W-1:0] w_nx;
  logic [W-1:0] w_ny;

  // Rotations by constant amounts, wrapping within one word
  function automatic logic [W-1:0] ror_w(input logic [W-1:0] v, input int amt);
    logic [2*W-1:0] t;
    t = {v, v} >> amt;
    return t[W-1:0];
  endfunction

  function automatic logic [W-1:0] rol_w(input logic [W-1:0] v, input int amt);
    logic [2*W-1:0] t;
    t = {v, v} << amt;
    return t[2*W-1:W];
  endfunction

  // One round in each direction; sums and differences wrap modulo 2^W
  always_comb begin
    w_enc_x = (ror_w(r_x, ALPHA) + r_y) ^ key;
    w_enc_y = rol_w(r_y, BETA) ^ w_enc_x;
    w_dec_y = ror_w(r_x ^ r_y, BETA);
    w_dec_x = rol_w((r_x ^ key) - w_dec_y, ALPHA);
    w_nx    = r_mode ? w_dec_x : w_enc_x;
    w_ny    = r_mode ? w_dec_y : w_enc_y;
  end

  assign in_ready       = (r_state == S_IDLE) && rst_n;
  assign key_ready      = (r_state == S_KEY);
  assign out_data       = r_out_data;
  assign out_valid      = r_out_valid;
  assign rounds_done    = r_rounds_done;
  assign state_response = r_state;

  // Control FSM: accept block, consume one key per round, hold result until taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_x           <= '0;
      r_y           <= '0;
      r_mode        <= 1'b0;
      r_remaining   <= '0;
      r_rounds_done <= '0;
      r_out_data    <= '0;
      r_out_valid   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_x           <= in_data[W-1:0];
            r_y           <= in_data[2*W-1:W];
            r_mode        <= mode;
            r_remaining   <= in_rounds;
            r_rounds_done <= '0;
            if (in_rounds == '0) begin
              r_out_data  <= in_data;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_state     <= S_KEY;
            end
          end
        end
        S_KEY: begin
          if (key_valid) begin
            r_x           <= w_nx;
            r_y           <= w_ny;
            r_remaining   <= r_remaining - 1'b1;
            r_rounds_done <= r_rounds_done + 1'b1;
            if (r_remaining == ROUND_WIDTH'(1)) begin
              r_out_data  <= {w_ny, w_nx};
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_speck_round_engine.sv
// tb/tb_speck_round_engine.sv - directed-vector self-checking bench for speck_round_engine
module tb_speck_round_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode;
  logic [31:0] in_data;
  logic [5:0]  in_rounds;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] key;
  logic        key_valid;
  logic        key_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  rounds_done;
  logic [1:0]  state_response;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] kbuf [0:33];

  logic [31:0] res;
  int          lat;
  int          gcnt;

  always #5 clk = ~clk;

  speck_round_engine #(
    .WORD_SIZE(16), .ALPHA(7), .BETA(2), .ROUND_WIDTH(6)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_data(in_data), .in_rounds(in_rounds),
    .in_valid(in_valid), .in_ready(in_ready), .key(key), .key_valid(key_valid),
    .key_ready(key_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .rounds_done(rounds_done), .state_response(state_response)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ror16(input logic [15:0] v, input int a);
    return (v >> a) | (v << (16 - a));
  endfunction

  function automatic logic [15:0] rol16(input logic [15:0] v, input int a);
    return (v << a) | (v >> (16 - a));
  endfunction

  // SPECK32/64 key schedule for key 0x1918111009080100; rev gives decrypt order
  task automatic gen_keys(input bit rev);
    logic [15:0] l [0:23];
    logic [15:0] k;
    logic [15:0] sched [0:21];
    k    = 16'h0100;
    l[0] = 16'h0908;
    l[1] = 16'h1110;
    l[2] = 16'h1918;
    for (int i = 0; i < 21; i++) begin
      sched[i] = k;
      l[i+3]   = (k + ror16(l[i], 7)) ^ 16'(i);
      k        = rol16(k, 2) ^ l[i+3];
    end
    sched[21] = k;
    for (int i = 0; i < 22; i++) kbuf[i] = rev ? sched[21-i] : sched[i];
  endtask

  task automatic run_block(input logic m, input logic [31:0] d, input int n, input bit gaps,
                           output logic [31:0] r, output int lt, output int gc);
    int idx;
    int cyc;
    bit hs;
    idx = 0; cyc = 0; lt = 0; gc = 0;
    @(negedge clk);
    mode = m; in_data = d; in_rounds = 6'(n); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lt = 1;
    while (!out_valid && cyc < 400) begin
      @(negedge clk);
      key_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      key = (idx < 34) ? kbuf[idx] : 16'h0;
      hs = key_valid && key_ready;
      if (key_ready && !key_valid) gc++;
      @(posedge clk); #1;
      if (hs) idx++;
      lt++;
      cyc++;
    end
    key_valid = 1'b0;
    check_eq("out_valid_done", out_valid, 1);
    r = out_data;
  endtask

  task automatic take_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq("out_valid_after_take", out_valid, 0);
    check_eq("in_ready_after_take", in_ready, 1);
  endtask

  initial begin
    rst_n = 1'b0; mode = 1'b0; in_data = '0; in_rounds = '0; in_valid = 1'b0;
    key = '0; key_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_key_ready", key_ready, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_state", state_response, 0);
    rst_n = 1'b1;
    #1;
    check_eq("post_rst_in_ready", in_ready, 1);

    kbuf[0] = 16'h00FF;
    run_block(1'b0, 32'h0000_0001, 1, 1'b0, res, lat, gcnt);
    check_eq("enc1_data", res, 32'h02FF_02FF);
    check_eq("enc1_latency", lat, 2);
    check_eq("enc1_rounds_done", rounds_done, 1);
    check_eq("enc1_state", state_response, 2);
    take_out();

    run_block(1'b1, 32'h02FF_02FF, 1, 1'b0, res, lat, gcnt);
    check_eq("dec1_data", res, 32'h0000_0001);
    take_out();

    kbuf[0] = 16'h0000;
    run_block(1'b0, 32'h0001_FFFF, 1, 1'b0, res, lat, gcnt);
    check_eq("carry_data", res, 32'h0004_0000);
    take_out();

    gen_keys(1'b0);
    run_block(1'b0, 32'h694C_6574, 22, 1'b1, res, lat, gcnt);
    check_eq("speck32_enc", res, 32'h42F2_A868);
    check_eq("speck32_rounds_done", rounds_done, 22);
    check_eq("speck32_latency", lat, 23 + gcnt);
    take_out();

    gen_keys(1'b1);
    run_block(1'b1, 32'h42F2_A868, 22, 1'b1, res, lat, gcnt);
    check_eq("speck32_dec", res, 32'h694C_6574);
    check_eq("speck32_dec_latency", lat, 23 + gcnt);
    take_out();

    run_block(1'b0, 32'hDEAD_BEEF, 0, 1'b0, res, lat, gcnt);
    check_eq("zero_rounds_data", res, 32'hDEAD_BEEF);
    check_eq("zero_rounds_latency", lat, 1);
    check_eq("zero_rounds_done", rounds_done, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = 32'h1234_5678; in_rounds = 6'd3; key_valid = 1'b1;
      @(posedge clk); #1;
      check_eq("bp_out_data", out_data, 32'hDEAD_BEEF);
      check_eq("bp_out_valid", out_valid, 1);
      check_eq("bp_in_ready", in_ready, 0);
      check_eq("bp_rounds_done", rounds_done, 0);
    end
    in_valid = 1'b0; key_valid = 1'b0;
    take_out();

    gen_keys(1'b0);
    @(negedge clk);
    mode = 1'b0; in_data = 32'h694C_6574; in_rounds = 6'd22; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    key_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      key = kbuf[i];
      @(posedge clk); #1;
    end
    check_eq("mid_rounds_done", rounds_done, 10);
    check_eq("mid_key_ready", key_ready, 1);
    #2;
    rst_n = 1'b0;
    key_valid = 1'b0;
    #1;
    check_eq("mid_rst_state", state_response, 0);
    check_eq("mid_rst_out_data", out_data, 0);
    check_eq("mid_rst_out_valid", out_valid, 0);
    check_eq("mid_rst_rounds_done", rounds_done, 0);
    check_eq("mid_rst_in_ready", in_ready, 0);
    check_eq("mid_rst_key_ready", key_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rel_in_ready", in_ready, 1);

    kbuf[0] = 16'h00FF;
    run_block(1'b0, 32'h0000_0001, 1, 1'b0, res, lat, gcnt);
    check_eq("fresh_enc_data", res, 32'h02FF_02FF);
    check_eq("fresh_rounds_done", rounds_done, 1);
    take_out();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
